apb_wrr_scheduler: RTL and testbench
====================================

Name: apb_wrr_scheduler

Overview:
- APB-programmable weighted round-robin scheduler that shares one resource between 4 requesters.
- Drives a registered one-hot GNT. Each grant tenure lasts up to WEIGHTn cycles, then rotates to the next eligible requester.
- Sits beside the APB arbiter subsystem as its time-sliced replacement path. The APB slave exposes enable, per-requester weights and live status.

Parameters:
- NREQ, 4, number of requesters (RTL and register map are written for 4).
- WW, 4, weight/tenure counter width.
- RST_WEIGHT, 1, reset value of every WEIGHTn register.
- STARVE_LIMIT, 15, wait cycles before starvation promotion (used only with the optional feature).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset; asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write
- PADDR  in  8  register address
- PWDATA  in  8  write data
- PRDATA  out  8  read data
- PREADY  out  1  always 1 (zero wait states)
- REQ  in  NREQ  requester request lines, level-sensitive
- GNT  out  NREQ  registered one-hot grant, or 0

Behaviour:
- Reset (async, PRESETn=0):
  - GNT=0, PRDATA=0, CTRL.EN=0.
  - WEIGHT0..3=RST_WEIGHT.
  - Rotation pointer=0, tenure counter=0, FSM=IDLE.
- APB register map:
  - Writes commit on the PCLK edge where PSEL&PENABLE&PWRITE.
  - PRDATA is combinational and valid when PSEL&PENABLE&!PWRITE; otherwise 0. Unmapped addresses read 0, and writes to them are ignored.
  - 0x00 CTRL: bit0 EN; bits7:1 read 0.
  - 0x01..0x04 WEIGHT0..3: bits[WW-1:0]. Weight 0 = requester masked, never granted.
  - 0x05 STATUS (RO): [3:0]=GNT, [7:4]=current tenure count.
- Eligibility: REQ[i] & (WEIGHT[i]!=0) & EN.
- Selection: first eligible index at or after the pointer, searching upward modulo 4.
- FSM IDLE:
  - If any requester is eligible, GNT<=onehot(sel) on the next edge, counter<=1, go to BUSY.
  - Otherwise stay in IDLE with GNT=0.
- FSM BUSY, granted index g. Release occurs when:
  - REQ[g]=0, or
  - counter==WEIGHT[g] (tenure exhausted), or
  - EN=0, or
  - WEIGHT[g] was written to 0.
- On release:
  - Pointer<=g+1 (mod 4).
  - The next selection uses the new pointer and is evaluated in the same cycle, so handover is zero-gap: GNT switches directly from onehot(g) to onehot(h).
  - If nothing is eligible, GNT<=0 and go to IDLE.
  - If g is the only eligible requester and its tenure exhausted, it is re-granted with counter=1, so GNT stays high continuously.
- Non-release BUSY cycle: counter<=counter+1. The counter saturates at 2^WW-1 and never wraps.
- Latency: REQ rising in IDLE gives GNT high on the 1st edge after it; max GNT high per tenure = WEIGHT[g] cycles.
- Weight writes to a granted requester (nonzero value): the new value is compared from the following cycle. If the counter is already >= the new weight, release happens on the next edge.
- EN cleared mid-tenure: GNT=0 on the next edge; pointer advances as for a normal release.
- Simultaneous APB write and release on the same edge: arbitration uses the register values from before the write.
- GNT is never multi-hot and never points at a non-requesting index for more than 1 cycle (registered-response allowance).

Optional Feature:
- Macro: WRR_STARVE_PROMOTE_EN.
- Defined:
  - Per-requester wait counter, incremented each cycle the requester is eligible but not granted, and cleared when granted or not eligible.
  - A requester whose wait counter reaches STARVE_LIMIT is selected before pointer order at the next selection point. Ties go to the lowest index.
  - STATUS bits[7:4] then show the max wait count instead of the tenure count.
- Undefined: pure weighted round-robin; no wait counters are synthesized.

Test Plan:
- Reset then read 0x01..0x05 -> reads 1, 1, 1, 1, 0; GNT=0 with REQ=4'hF and EN=0.
- EN=1, WEIGHT={1,1,1,1}, REQ=4'hF held -> GNT sequence 1,2,4,8,1,... each 1 cycle, no gaps.
- WEIGHT0=3, WEIGHT1=2, REQ=4'b0011 held -> GNT=1 for 3 cycles, then 2 for 2 cycles, repeating; STATUS[7:4] counts 1..3.
- WEIGHT2=0, REQ=4'b0100 -> GNT stays 0; write WEIGHT2=2 -> GNT=4 on the edge after the write.
- REQ0 dropped mid-tenure (WEIGHT0=8, REQ=4'b0011) -> GNT switches 1->2 on the next edge; clear EN mid-tenure -> GNT=0 next edge.
- PRESETn asserted while GNT=4'b0100 -> GNT=0 and CTRL=0 immediately (asynchronous); after release, GNT=0 until EN is rewritten.

Source files
------------

// File: rtl/apb_wrr_scheduler.sv
// APB-programmable weighted round-robin scheduler: one registered one-hot grant shared by 4 requesters.
// Optional starvation promotion is compiled in when WRR_STARVE_PROMOTE_EN is defined.
module apb_wrr_scheduler #(
  parameter int NREQ         = 4,
  parameter int WW           = 4,
  parameter int RST_WEIGHT   = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [7:0]      PADDR,
  input  logic [7:0]      PWDATA,
  output logic [7:0]      PRDATA,
  output logic            PREADY,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT
);

  // APB: a write commits on the edge where PSEL & PENABLE & PWRITE; reads are
  // combinational in the access phase and return 0 otherwise. PREADY is tied high.
  localparam int IW = $clog2(NREQ);
  localparam logic [WW-1:0]   RST_W   = WW'(RST_WEIGHT);
  localparam logic [WW-1:0]   CNT_MAX = '1;
  localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic [NREQ-1:0][WW-1:0] weight_q, weight_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [WW-1:0]           cnt_q, cnt_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;

  logic                    wr_en, rd_en;
  logic [NREQ-1:0]         elig;
  logic [IW-1:0]           base, cand, sel_idx;
  logic                    sel_found;
  logic                    release_c, grant_sel;
  logic [3:0]              status_nib;
  logic                    unused_pwdata;

`ifdef WRR_STARVE_PROMOTE_EN
  localparam logic [WW-1:0] STARVE_W = WW'(STARVE_LIMIT);
  logic [NREQ-1:0][WW-1:0] wait_q, wait_d;
  logic [WW-1:0]           wait_max;
`endif

  assign wr_en         = PSEL & PENABLE & PWRITE;
  assign rd_en         = PSEL & PENABLE & ~PWRITE;
  assign PREADY        = 1'b1;
  assign GNT           = gnt_q;
  assign unused_pwdata = ^PWDATA;

  always_comb begin
    en_d     = en_q;
    weight_d = weight_q;
    if (wr_en) begin
      case (PADDR)
        8'h00:   en_d        = PWDATA[0];
        8'h01:   weight_d[0] = PWDATA[WW-1:0];
        8'h02:   weight_d[1] = PWDATA[WW-1:0];
        8'h03:   weight_d[2] = PWDATA[WW-1:0];
        8'h04:   weight_d[3] = PWDATA[WW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = REQ[i] & (weight_q[i] != '0) & en_q;
    end
  end

  // On release the search starts just past the current owner, which is the new pointer.
  always_comb begin
    base      = (state_q == S_BUSY) ? gidx_q + IW'(1) : ptr_q;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = base + IW'(k);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
`ifdef WRR_STARVE_PROMOTE_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[k] && (wait_q[k] >= STARVE_W)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(k);
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    release_c = 1'b0;
    grant_sel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) grant_sel = 1'b1;
      end
      S_BUSY: begin
        release_c = ~REQ[gidx_q] | ~en_q | (weight_q[gidx_q] == '0) |
                    (cnt_q >= weight_q[gidx_q]);
        if (release_c) begin
          ptr_d = gidx_q + IW'(1);
          if (sel_found) begin
            grant_sel = 1'b1;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + WW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (grant_sel) begin
      state_d = S_BUSY;
      gidx_d  = sel_idx;
      gnt_d   = ONE_HOT << sel_idx;
      cnt_d   = WW'(1);
    end
  end

`ifdef WRR_STARVE_PROMOTE_EN
  always_comb begin
    wait_max = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] >= STARVE_W) ? wait_q[i] : wait_q[i] + WW'(1);
      end else begin
        wait_d[i] = '0;
      end
      if (wait_q[i] > wait_max) wait_max = wait_q[i];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_q <= '0;
    else          wait_q <= wait_d;
  end

  assign status_nib = 4'(wait_max);
`else
  assign status_nib = 4'(cnt_q);
`endif

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (PADDR)
        8'h00:   PRDATA = {7'b0, en_q};
        8'h01:   PRDATA = 8'(weight_q[0]);
        8'h02:   PRDATA = 8'(weight_q[1]);
        8'h03:   PRDATA = 8'(weight_q[2]);
        8'h04:   PRDATA = 8'(weight_q[3]);
        8'h05:   PRDATA = {status_nib, gnt_q};
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      weight_q <= {NREQ{RST_W}};
      ptr_q    <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      weight_q <= weight_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
    end
  end

endmodule

// File: tb/tb_apb_wrr_scheduler.sv
// Bench for apb_wrr_scheduler: directed and random APB/REQ traffic scored against a behavioural model.
`timescale 1ns/1ps
module tb_apb_wrr_scheduler;

  localparam int STARVE_LIMIT = 15;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b0;
  logic       PSEL    = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE  = 1'b0;
  logic [7:0] PADDR   = 8'h00;
  logic [7:0] PWDATA  = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic [3:0] REQ     = 4'h0;
  logic [3:0] GNT;

  apb_wrr_scheduler #(
    .NREQ(4), .WW(4), .RST_WEIGHT(1), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .REQ(REQ), .GNT(GNT)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  // scoreboard
  logic [3:0] exp_q[$];
  logic [7:0] rd_exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: owner index (-1 = none), cycles served, rotation start
  int m_en, m_ptr, m_g, m_cnt;
  int m_w[4];
  int m_wait[4];

  task automatic m_reset();
    m_en = 0; m_ptr = 0; m_g = -1; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 1;
      m_wait[i] = 0;
    end
  endtask

  function automatic bit m_elig(input int i, input logic [3:0] req);
    return req[i] && (m_w[i] != 0) && (m_en != 0);
  endfunction

  function automatic int m_pick(input int start, input logic [3:0] req);
`ifdef WRR_STARVE_PROMOTE_EN
    for (int i = 0; i < 4; i++)
      if (m_elig(i, req) && m_wait[i] >= STARVE_LIMIT) return i;
`endif
    for (int k = 0; k < 4; k++)
      if (m_elig((start + k) % 4, req)) return (start + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    if (m_g < 0) return 4'h0;
    return 4'(1 << m_g);
  endfunction

  function automatic logic [7:0] m_read(input int addr);
    int st;
    st = m_cnt;
`ifdef WRR_STARVE_PROMOTE_EN
    st = 0;
    for (int i = 0; i < 4; i++) if (m_wait[i] > st) st = m_wait[i];
`endif
    case (addr)
      0:          return 8'(m_en);
      1, 2, 3, 4: return 8'(m_w[addr-1]);
      5:          return {4'(st), m_gnt()};
      default:    return 8'h00;
    endcase
  endfunction

  task automatic m_step(input logic [3:0] req, input bit wr, input int addr, input int data);
    int old_g, h;
    bit el[4];
    old_g = m_g;
    for (int i = 0; i < 4; i++) el[i] = m_elig(i, req);
    if (m_g < 0) begin
      h = m_pick(m_ptr, req);
      if (h >= 0) begin m_g = h; m_cnt = 1; end
    end else if (!req[m_g] || m_en == 0 || m_cnt >= m_w[m_g]) begin
      m_ptr = (m_g + 1) % 4;
      h = m_pick(m_ptr, req);
      if (h >= 0) begin m_g = h; m_cnt = 1; end
      else begin m_g = -1; m_cnt = 0; end
    end else if (m_cnt < 15) begin
      m_cnt++;
    end
    for (int i = 0; i < 4; i++)
      m_wait[i] = (el[i] && old_g != i) ? ((m_wait[i] < STARVE_LIMIT) ? m_wait[i] + 1 : m_wait[i]) : 0;
    if (wr) begin
      if (addr == 0) m_en = data & 1;
      else if (addr >= 1 && addr <= 4) m_w[addr-1] = data & 15;
    end
  endtask

  // driver tasks: inputs change 2ns after the rising edge
  task automatic drive(input logic [3:0] req, input bit sel, input bit ena, input bit wr,
                       input int addr, input int data);
    @(posedge PCLK); #2;
    REQ = req; PSEL = sel; PENABLE = ena; PWRITE = wr;
    PADDR = 8'(addr); PWDATA = 8'(data);
    if (sel && ena && !wr) rd_exp_q.push_back(m_read(addr));
    m_step(req, sel && ena && wr, addr, data);
    exp_q.push_back(m_gnt());
  endtask

  task automatic idle(input logic [3:0] req, input int n);
    repeat (n) drive(req, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic apb_write(input logic [3:0] req, input int addr, input int data);
    drive(req, 1'b1, 1'b0, 1'b1, addr, data);
    drive(req, 1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic apb_read(input logic [3:0] req, input int addr);
    drive(req, 1'b1, 1'b0, 1'b0, addr, 0);
    drive(req, 1'b1, 1'b1, 1'b0, addr, 0);
  endtask

  // monitors
  always @(posedge PCLK) begin : mon_gnt
    logic [3:0] e;
    #1;
    if (PRESETn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt", 8'(GNT), 8'(e));
      check("gnt_onehot", 8'($onehot0(GNT)), 8'h01);
    end
  end

  always @(negedge PCLK) begin : mon_rd
    logic [7:0] e;
    if (PRESETn && PSEL && PENABLE && !PWRITE && rd_exp_q.size() > 0) begin
      e = rd_exp_q.pop_front();
      check("prdata", PRDATA, e);
    end
  end

  initial begin
    m_reset();
    #2;
    check("reset_gnt", 8'(GNT), 8'h00);
    check("reset_prdata", PRDATA, 8'h00);
    check("pready", 8'(PREADY), 8'h01);
    #18 PRESETn = 1'b1;

    // reset register values, EN=0 keeps GNT low with all requesting
    for (int a = 1; a <= 5; a++) apb_read(4'hF, a);
    apb_read(4'hF, 0);
    idle(4'hF, 3);

    // equal weights: 1,2,4,8 rotation
    apb_write(4'hF, 0, 1);
    idle(4'hF, 12);

    // weights 3/2 on requesters 0/1
    apb_write(4'hF, 1, 3);
    apb_write(4'hF, 2, 2);
    idle(4'h3, 6);
    repeat (4) apb_read(4'h3, 5);
    idle(4'h3, 4);

    // masked requester, then unmasked by weight write
    apb_write(4'h3, 3, 0);
    idle(4'h4, 5);
    apb_write(4'h4, 3, 2);
    idle(4'h4, 5);

    // drop REQ0 mid-tenure
    apb_write(4'h3, 1, 8);
    for (int i = 0; i < 30; i++) begin
      if (m_g == 0 && m_cnt >= 2 && m_cnt < 6) break;
      idle(4'h3, 1);
    end
    idle(4'h2, 3);
    idle(4'h3, 4);
    apb_write(4'h3, 0, 0);
    idle(4'h3, 4);
    apb_read(4'h3, 5);

    // randomized traffic
    apb_write(4'hF, 0, 1);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      int op, a, d;
      r  = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if (op < 6) begin
        idle(r, $urandom_range(1, 4));
      end else if (op < 8) begin
        a = $urandom_range(0, 7);
        d = (a == 0) ? int'($urandom_range(0, 4) != 0) : $urandom_range(0, 5);
        if (a > 5) d = $urandom_range(0, 255);
        apb_write(r, a, d);
      end else begin
        apb_read(r, $urandom_range(0, 7));
      end
    end

    // asynchronous reset while requester 2 holds the grant
    apb_write(4'h4, 0, 1);
    apb_write(4'h4, 3, 2);
    idle(4'h4, 4);
    @(posedge PCLK); #3;
    check("pre_reset_gnt", 8'(GNT), 8'(m_gnt()));
    check("pre_reset_model", 8'(m_gnt()), 8'h04);
    PRESETn = 1'b0;
    #1 check("async_gnt", 8'(GNT), 8'h00);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h00;
    #1 check("async_ctrl", PRDATA, 8'h00);
    m_reset();
    PSEL = 1'b0; PENABLE = 1'b0; REQ = 4'hF;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) PRESETn = 1'b1;
    idle(4'hF, 6);
    apb_read(4'hF, 0);
    apb_read(4'hF, 3);
    apb_write(4'hF, 0, 1);
    idle(4'hF, 8);

    @(posedge PCLK); #3;
    check("drain", 8'(exp_q.size() + rd_exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
